// File: rtl/home_event_scheduler.sv
// -----------------------------------------------------------------------------
// home_event_scheduler
//
// Purpose:
//   Round-robin event scheduler for a home automation controller. It serves
//   N_SENSORS discrete sensor channels plus a heater channel and a cooler
//   channel. The heater and cooler requests come from programmable temperature
//   thresholds with hysteresis. A scan pointer visits the channels in order.
//   Each granted event is shown on the display for exactly HOLD_CYCLES cycles,
//   and the pointer then moves past the served channel. This rotation keeps
//   service fair and stops any channel from starving.
//
// Ports:
//   clk          in   1           system clock
//   reset        in   1           synchronous, active-high reset
//   sensors      in   N_SENSORS   level request per sensor channel
//   ST           in   1           temperature sensor enable
//   temperature  in   TEMP_W      current temperature (unsigned)
//   display      out  CODE_W      0 = idle, i+1 = sensor i,
//                                 N+1 = heater, N+2 = cooler
//   actuator     out  NCH         one-hot of display-1, zero when idle
//   busy         out  1           FSM is not in IDLE
//
// Configuration:
//   HES_PREEMPT_EN  When defined, a front-door request (sensor 0) preempts the
//                   event currently held. sensor 0 is then granted at once
//                   with a fresh hold period and the pointer is reset to 0.
//                   When undefined, sensor 0 waits for its round-robin turn.
// -----------------------------------------------------------------------------
module home_event_scheduler #(
    parameter  int N_SENSORS   = 5,
    parameter  int TEMP_W      = 6,
    parameter  int TEMP_LO     = 18,
    parameter  int TEMP_HI     = 30,
    parameter  int HYST        = 2,
    parameter  int HOLD_CYCLES = 4,
    localparam int NCH         = N_SENSORS + 2,
    localparam int CODE_W      = $clog2(NCH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SENSORS-1:0] sensors,
    input  logic                 ST,
    input  logic [TEMP_W-1:0]    temperature,
    output logic [CODE_W-1:0]    display,
    output logic [NCH-1:0]       actuator,
    output logic                 busy
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int PTR_W = $clog2(NCH);
    localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [TEMP_W-1:0] HEAT_ON_T  = TEMP_W'(TEMP_LO);
    localparam logic [TEMP_W-1:0] HEAT_OFF_T = TEMP_W'(TEMP_LO + HYST);
    localparam logic [TEMP_W-1:0] COOL_ON_T  = TEMP_W'(TEMP_HI);
    localparam logic [TEMP_W-1:0] COOL_OFF_T = TEMP_W'(TEMP_HI - HYST);

    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(NCH - 1);
    localparam logic [HC_W-1:0]   HOLD_LOAD  = HC_W'(HOLD_CYCLES - 1);
    localparam logic [CODE_W-1:0] CODE_FRONT = CODE_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                 state_q,    state_d;
    logic [PTR_W-1:0]       ptr_q,      ptr_d;
    logic [CODE_W-1:0]      display_q,  display_d;
    logic [HC_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic [N_SENSORS-1:0]   req_q;
    logic                   heat_req_q, heat_req_d;
    logic                   cool_req_q, cool_req_d;

    logic [NCH-1:0]         req_vec;
    logic                   any_req;
    logic [PTR_W-1:0]       ptr_inc;
    logic                   preempt;

    // -------------------------------------------------------------------------
    // Thermal hysteresis
    // A request sets once the temperature crosses its threshold. It clears only
    // after the temperature has moved HYST degrees back. This band stops the
    // heater or cooler from chattering around the threshold. Dropping ST
    // clears both requests at once.
    // -------------------------------------------------------------------------
    always_comb begin
        heat_req_d = heat_req_q;
        cool_req_d = cool_req_q;

        if (!ST) begin
            heat_req_d = 1'b0;
        end else if (temperature < HEAT_ON_T) begin
            heat_req_d = 1'b1;
        end else if (temperature >= HEAT_OFF_T) begin
            heat_req_d = 1'b0;
        end

        if (!ST) begin
            cool_req_d = 1'b0;
        end else if (temperature > COOL_ON_T) begin
            cool_req_d = 1'b1;
        end else if (temperature <= COOL_OFF_T) begin
            cool_req_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Request vector and pointer arithmetic
    // -------------------------------------------------------------------------
    assign req_vec = {cool_req_q, heat_req_q, req_q};
    assign any_req = |req_vec;
    assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);

`ifdef HES_PREEMPT_EN
    // The front door is treated as an emergency. It takes over any hold that
    // is not already showing the front door itself.
    assign preempt = (state_q == HOLD) && req_q[0] && (display_q != CODE_FRONT);
`else
    assign preempt = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Scheduler FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        display_d  = display_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            IDLE: begin
                // The pointer stays where it is, so service resumes at the
                // channel after the one served last.
                if (any_req) begin
                    state_d = SCAN;
                end
            end

            SCAN: begin
                if (!any_req) begin
                    state_d = IDLE;
                end else if (req_vec[ptr_q]) begin
                    display_d  = CODE_W'(ptr_q) + CODE_W'(1);
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = HOLD;
                end else begin
                    ptr_d = ptr_inc;
                end
            end

            HOLD: begin
                if (preempt) begin
                    display_d  = CODE_FRONT;
                    ptr_d      = '0;
                    hold_cnt_d = HOLD_LOAD;
                end else if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HC_W'(1);
                end else begin
                    // The hold has run its full length, whatever the request
                    // did meanwhile. Move past the served channel so every
                    // other requester is visited before this one again.
                    display_d = '0;
                    ptr_d     = ptr_inc;
                    state_d   = any_req ? SCAN : IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                display_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            display_q  <= '0;
            hold_cnt_q <= '0;
            req_q      <= '0;
            heat_req_q <= 1'b0;
            cool_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            display_q  <= display_d;
            hold_cnt_q <= hold_cnt_d;
            req_q      <= sensors;
            heat_req_q <= heat_req_d;
            cool_req_q <= cool_req_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // The actuator is decoded straight from the display register. It
    // therefore changes in the same cycle as the display and depends only on
    // that one register.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_act
            assign actuator[gi] = (display_q == CODE_W'(gi + 1));
        end
    endgenerate

    assign display = display_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_home_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_home_event_scheduler
//
// Directed bench for home_event_scheduler with the default parameters
// (5 sensors, hold of 4 cycles, thresholds 18/30, hysteresis 2).
// The stimulus process pushes the expected grants into a queue. Each grant is
// given as code, length and first edge. A monitor rebuilds the grants from the
// display output and checks them against the queue. The monitor also checks
// on every cycle that the actuator is the one-hot form of the display.
// -----------------------------------------------------------------------------
module tb_home_event_scheduler;

    localparam int N      = 5;
    localparam int NCH    = N + 2;
    localparam int CODE_W = $clog2(NCH + 1);

    logic              clk;
    logic              reset;
    logic [N-1:0]      sensors;
    logic              ST;
    logic [5:0]        temperature;
    logic [CODE_W-1:0] display;
    logic [NCH-1:0]    actuator;
    logic              busy;

    home_event_scheduler #(
        .N_SENSORS   (N),
        .TEMP_W      (6),
        .TEMP_LO     (18),
        .TEMP_HI     (30),
        .HYST        (2),
        .HOLD_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sensors     (sensors),
        .ST          (ST),
        .temperature (temperature),
        .display     (display),
        .actuator    (actuator),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after posedge k (and until the next one) cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int code;
        int len;
        int start;
    } grant_t;

    grant_t exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_grant(input int code, input int len, input int start);
        grant_t g;
        g.code  = code;
        g.len   = len;
        g.start = start;
        exp_q.push_back(g);
    endtask

    task automatic goto_edge(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset       = 1'b1;
        sensors     = '0;
        ST          = 1'b0;
        temperature = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    int  mon_d;
    int  prev_d    = 0;
    bit  in_grant  = 1'b0;
    int  cur_code  = 0;
    int  cur_len   = 0;
    int  cur_start = 0;

    task automatic close_grant();
        grant_t g;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_grant: got code %0d len %0d start %0d, expected none",
                     cur_code, cur_len, cur_start);
        end else begin
            g = exp_q.pop_front();
            $display("grant code=%0d len=%0d start=%0d (expected code=%0d len=%0d start=%0d)",
                     cur_code, cur_len, cur_start, g.code, g.len, g.start);
            chk("grant_code",  cur_code,  g.code);
            chk("grant_len",   cur_len,   g.len);
            chk("grant_start", cur_start, g.start);
        end
    endtask

    always @(negedge clk) begin
        mon_d = int'(display);
        chk("actuator_onehot", int'(actuator), (mon_d == 0) ? 0 : (1 << (mon_d - 1)));
        if (mon_d != prev_d) begin
            if (in_grant) close_grant();
            in_grant = (mon_d != 0);
            if (mon_d != 0) begin
                cur_code  = mon_d;
                cur_start = cyc;
                cur_len   = 0;
            end
        end
        if (mon_d != 0) cur_len++;
        prev_d = mon_d;
    end

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    int p;
    int q;

    initial begin
        reset       = 1'b1;
        sensors     = '0;
        ST          = 1'b0;
        temperature = '0;

        // Reset held for 5 cycles: all outputs quiet.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_display",  int'(display),  0);
            chk("reset_actuator", int'(actuator), 0);
            chk("reset_busy",     int'(busy),     0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        p = cyc;
        goto_edge(p + 3);
        chk("idle_busy",    int'(busy),    0);
        chk("idle_display", int'(display), 0);

        // Single request on sensor 2. The scan walks ptr 0->2 and grants at +5.
        // The sensor drops during the hold, and the hold still completes.
        p = cyc;
        sensors = 5'b00100;
        expect_grant(3, 4, p + 5);
        goto_edge(p + 5);
        sensors = '0;
        goto_edge(p + 12);
        chk("single_done_busy", int'(busy), 0);

        // Sensors 0 and 4 held: grants alternate 1,5,1,5 with wrap.
        do_reset();
        p = cyc;
        sensors = 5'b10001;
        expect_grant(1, 4, p + 3);
        expect_grant(5, 4, p + 11);
        expect_grant(1, 4, p + 18);
        expect_grant(5, 4, p + 26);
        goto_edge(p + 26);
        sensors = '0;
        goto_edge(p + 34);
        chk("rr_done_busy", int'(busy), 0);

        // Heater: 17 sets the request, 19 keeps it (a second grant follows),
        // 20 clears it.
        do_reset();
        p = cyc;
        ST          = 1'b1;
        temperature = 6'd17;
        expect_grant(6, 4, p + 8);
        expect_grant(6, 4, p + 19);
        goto_edge(p + 8);
        temperature = 6'd19;
        goto_edge(p + 19);
        temperature = 6'd20;
        goto_edge(p + 25);
        chk("heat_cleared_busy", int'(busy), 0);

        // Cooler: 31 sets it, 28 clears it. The pointer sits at 6 after the
        // heater grant, so the cooler is granted right after SCAN starts.
        q = cyc;
        temperature = 6'd31;
        expect_grant(7, 4, q + 3);
        goto_edge(q + 3);
        temperature = 6'd28;
        goto_edge(q + 10);
        chk("cool_cleared_busy", int'(busy), 0);

        // ST low: a cold reading raises no request.
        ST          = 1'b0;
        temperature = 6'd10;
        goto_edge(q + 16);
        chk("st_off_busy",    int'(busy),    0);
        chk("st_off_display", int'(display), 0);
        temperature = '0;

        // Reset in the middle of a hold of code 3. Afterwards the held sensor
        // is granted again with the scan starting from ptr 0.
        do_reset();
        p = cyc;
        sensors = 5'b00100;
        expect_grant(3, 2, p + 5);
        expect_grant(3, 4, p + 12);
        goto_edge(p + 6);
        reset = 1'b1;
        goto_edge(p + 7);
        reset = 1'b0;
        chk("midhold_reset_display", int'(display), 0);
        chk("midhold_reset_busy",    int'(busy),    0);
        goto_edge(p + 12);
        sensors = '0;
        goto_edge(p + 20);

        // Front door raised while code 4 is held.
        do_reset();
        p = cyc;
        sensors = 5'b01000;
`ifdef HES_PREEMPT_EN
        expect_grant(4, 3, p + 6);
        expect_grant(1, 4, p + 9);
`else
        expect_grant(4, 4, p + 6);
        expect_grant(1, 4, p + 14);
`endif
        goto_edge(p + 7);
        sensors = 5'b01001;
        goto_edge(p + 14);
        sensors = '0;
        goto_edge(p + 24);
        chk("front_done_busy", int'(busy), 0);

        goto_edge(cyc + 3);
        chk("pending_grants", exp_q.size(), 0);
        chk("grant_open",     int'(in_grant), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
